matrix_operand_loader: RTL and testbench

Upstream feeder for the 3x3 matrix multiplier. It accepts a serial stream of unsigned operand elements over a valid/ready handshake and assembles matrix A, then matrix B, in row-major order. It presents both matrices as flattened buses, pulses `start` for one cycle, then holds the operands stable until the multiplier reports completion. It then re-opens for the next operand pair.

---
 rtl/matrix_operand_loader.sv | 247 ++++++++++++++++++++++++
 tb/tb_matrix_operand_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
// ---------------------
// Upstream feeder for the NxN matrix multiplier. It accepts a serial stream of
// unsigned elements over a valid/ready handshake and fills matrix A, then
// matrix B, in row-major order. It then pulses `start` for one cycle and holds
// both operand buses stable until `mult_done` releases them.
//
// Optional feature macro: MATRIX_LOADER_FRAME_EN
//   When defined, the `in_last` / `frame_err` ports exist and every frame is
//   checked for a correctly placed end-of-frame marker. A misplaced marker
//   aborts the frame back to LOAD_A without issuing `start`.
//   When undefined, the loader relies on element counting alone.

module matrix_operand_loader #(
  parameter int BIT_LEN     = 8,
  parameter int MATRIX_SIZE = 3,
  parameter int CNT_W       = 4   // must satisfy 2**CNT_W > MATRIX_SIZE**2
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [BIT_LEN-1:0]                         in_data,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [BIT_LEN*MATRIX_SIZE*MATRIX_SIZE-1:0] mat_a_flat,
  output logic [BIT_LEN*MATRIX_SIZE*MATRIX_SIZE-1:0] mat_b_flat,
  output logic                                       start,
  input  logic                                       mult_done,
  output logic                                       busy
`ifdef MATRIX_LOADER_FRAME_EN
  ,
  input  logic                                       in_last,
  output logic                                       frame_err
`endif
);

  // ---------------------------------------------------------------------------
  // Local constants and types
  // ---------------------------------------------------------------------------
  localparam int ELEM_CNT = MATRIX_SIZE * MATRIX_SIZE;
  localparam int FLAT_W   = BIT_LEN * ELEM_CNT;

  // Index of the final slot in a matrix; reaching it closes the current matrix.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ELEM_CNT - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,  // filling matrix A (reset state)
    LOAD_B = 2'd1,  // filling matrix B
    FIRE   = 2'd2,  // single cycle in which start is high
    HOLD   = 2'd3   // operands frozen until the multiplier reports done
  } state_e;

  // ---------------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q,   idx_d;
  logic [FLAT_W-1:0]  mat_a_q, mat_a_d;
  logic [FLAT_W-1:0]  mat_b_q, mat_b_d;
  logic               start_q, start_d;
  logic               busy_q,  busy_d;

  // Decoded per-cycle control.
  logic               accept;     // element transferred this cycle
  logic               idx_last;   // current slot is the last one of a matrix
  logic               write_a;    // store in_data into A slot idx_q
  logic               write_b;    // store in_data into B slot idx_q
  logic               frame_bad;  // accepted element violates framing

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // Ready comes from the state register alone, so there is no combinational
  // path from in_valid back to in_ready.
  assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign accept   = in_valid && in_ready;
  assign idx_last = (idx_q == LAST_IDX);

`ifdef MATRIX_LOADER_FRAME_EN
  logic frame_err_q, frame_err_d;
  logic final_b;

  // in_last must be high on exactly the final B element of the frame; any
  // other placement (early, or missing on the final element) is a violation.
  assign final_b   = (state_q == LOAD_B) && idx_last;
  assign frame_bad = accept && (in_last != final_b);
`else
  assign frame_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM transitions, slot index and write enables
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    write_a = 1'b0;
    write_b = 1'b0;

    unique case (state_q)
      LOAD_A: begin
        if (accept) begin
          if (frame_bad) begin
            // Discard the element and restart the frame from slot 0.
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            write_a = 1'b1;
            if (idx_last) begin
              idx_d   = '0;
              state_d = LOAD_B;
            end else begin
              idx_d = idx_q + CNT_W'(1);
            end
          end
        end
      end

      LOAD_B: begin
        if (accept) begin
          if (frame_bad) begin
            idx_d   = '0;
            state_d = LOAD_A;
          end else begin
            write_b = 1'b1;
            if (idx_last) begin
              idx_d   = '0;
              state_d = FIRE;
            end else begin
              idx_d = idx_q + CNT_W'(1);
            end
          end
        end
      end

      // start is high for exactly this one cycle; mult_done is ignored here.
      FIRE: begin
        state_d = HOLD;
      end

      HOLD: begin
        if (mult_done) begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      end

      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase
  end

  // Operand slot decode: only the addressed slot of the selected matrix takes
  // the new element, all others keep their (possibly stale) contents.
  always_comb begin
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    for (int s = 0; s < ELEM_CNT; s++) begin
      if (write_a && (idx_q == CNT_W'(s))) begin
        mat_a_d[s*BIT_LEN +: BIT_LEN] = in_data;
      end
      if (write_b && (idx_q == CNT_W'(s))) begin
        mat_b_d[s*BIT_LEN +: BIT_LEN] = in_data;
      end
    end
  end

  // Registered status outputs, derived from where the FSM is about to be.
  always_comb begin
    start_d = (state_d == FIRE);
    busy_d  = (state_d != LOAD_A) || (idx_d != '0);
  end

`ifdef MATRIX_LOADER_FRAME_EN
  // Framing error is a one-cycle registered pulse following the bad element.
  always_comb begin
    frame_err_d = frame_bad;
  end
`endif

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------

  // FSM state and slot index register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its next value from the same pre-edge snapshot.
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Operand storage for matrices A and B.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the operand store is small and must read as zero after reset,
      // so it is reset like ordinary registers rather than left uninitialised
      // as a RAM would be.
      mat_a_q <= '0;
      mat_b_q <= '0;
    end else begin
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
    end
  end

  // Registered start pulse and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MATRIX_LOADER_FRAME_EN
  // Registered framing-error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign mat_a_flat = mat_a_q;
  assign mat_b_flat = mat_b_q;
  assign start      = start_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Testbench for matrix_operand_loader (N=3, 8-bit elements).
// A driver issues directed loads and pushes the expected operand pair and the
// expected start edge into a scoreboard queue; a monitor pops and compares
// whenever the DUT raises start. Build with +define+MATRIX_LOADER_FRAME_EN to
// include the framing scenarios.

module tb_matrix_operand_loader;

  localparam int BIT_LEN = 8;
  localparam int N       = 3;
  localparam int NN      = N * N;
  localparam int CNT_W   = 4;
  localparam int FW      = BIT_LEN * NN;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic [7:0]    in_data   = '0;
  logic          in_valid  = 1'b0;
  logic          mult_done = 1'b0;
  logic          in_last   = 1'b0;
  logic          in_ready;
  logic          start;
  logic          busy;
  logic [FW-1:0] mat_a_flat;
  logic [FW-1:0] mat_b_flat;
`ifdef MATRIX_LOADER_FRAME_EN
  logic          frame_err;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    int            edge_n;
  } exp_t;

  exp_t sb_q[$];

  matrix_operand_loader #(
    .BIT_LEN     (BIT_LEN),
    .MATRIX_SIZE (N),
    .CNT_W       (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mat_a_flat (mat_a_flat),
    .mat_b_flat (mat_b_flat),
    .start      (start),
    .mult_done  (mult_done),
    .busy       (busy)
`ifdef MATRIX_LOADER_FRAME_EN
    ,
    .in_last    (in_last),
    .frame_err  (frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Edge counter: at a falling edge, cyc equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference packing: element i of a matrix is base+i, row-major.
  function automatic logic [FW-1:0] pack(input logic [7:0] base);
    logic [FW-1:0] r;
    for (int i = 0; i < NN; i++) r[i*BIT_LEN +: BIT_LEN] = base + 8'(i);
    return r;
  endfunction

  // Monitor: every start pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && start) begin
      check("start_expected", (sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("start_edge", cyc, e.edge_n);
        check("start_mat_a", mat_a_flat, e.a);
        check("start_mat_b", mat_b_flat, e.b);
      end
    end
  end

  // One element offered for one cycle; called and returns on a falling edge.
  task automatic send(input logic [7:0] d, input bit last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    check("in_ready_load", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Full 18-element load of A=base.., B=base+9..; optional valid gaps and
  // mult_done held high for the first md_first elements.
  task automatic load(input logic [7:0] base, input bit toggle, input int md_first);
    exp_t e;
    e.a      = pack(base);
    e.b      = pack(base + 8'(NN));
    e.edge_n = cyc + (toggle ? (2 * (2*NN - 1) + 1) : 2*NN);
    sb_q.push_back(e);
    for (int i = 0; i < 2*NN; i++) begin
      mult_done = (i < md_first);
      send(base + 8'(i), (i == 2*NN - 1));
      if (toggle && (i != 2*NN - 1)) begin
        @(negedge clk);
        check("in_ready_gap", in_ready, 1);
      end
    end
    mult_done = 1'b0;
  endtask

  task automatic release_hold();
    mult_done = 1'b1;
    @(negedge clk);
    mult_done = 1'b0;
    check("in_ready_after_done", in_ready, 1);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mat_a", mat_a_flat, 0);
    check("rst_mat_b", mat_b_flat, 0);
`ifdef MATRIX_LOADER_FRAME_EN
    check("rst_frame_err", frame_err, 0);
`endif
    reset_n = 1'b1;

    // ---------------- continuous load 1..18 ----------------
    load(8'd1, 1'b0, 0);
    check("fire_in_ready", in_ready, 0);
    check("fire_busy", busy, 1);
    repeat (3) begin
      @(negedge clk);
      check("hold_in_ready", in_ready, 0);
      check("hold_start_low", start, 0);
    end
    check("slot_a_1_2", mat_a_flat[(1*N+2)*BIT_LEN +: BIT_LEN], 8'd6);
    check("slot_b_2_0", mat_b_flat[(2*N+0)*BIT_LEN +: BIT_LEN], 8'd16);

    // ---------------- valid flood while holding ----------------
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(negedge clk);
      check("flood_in_ready", in_ready, 0);
      check("flood_mat_a", mat_a_flat, pack(8'd1));
      check("flood_mat_b", mat_b_flat, pack(8'd10));
    end
    in_valid = 1'b0;
    release_hold();

    // ---------------- gapped load, mult_done in LOAD_A and FIRE ----------------
    load(8'd1, 1'b1, 4);
    mult_done = 1'b1;            // state is FIRE here; must be ignored
    @(negedge clk);
    mult_done = 1'b0;
    check("fire_done_ignored", in_ready, 0);
    check("fire_done_busy", busy, 1);
    repeat (2) @(negedge clk);
    release_hold();

    // ---------------- asynchronous reset mid-load ----------------
    for (int i = 0; i < 12; i++) send(8'h20 + 8'(i), 1'b0);
    check("midload_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_start", start, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_mat_a", mat_a_flat, 0);
    check("arst_mat_b", mat_b_flat, 0);
`ifdef MATRIX_LOADER_FRAME_EN
    check("arst_frame_err", frame_err, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    load(8'h40, 1'b0, 0);
    repeat (2) @(negedge clk);
    release_hold();

`ifdef MATRIX_LOADER_FRAME_EN
    // ---------------- framing: early in_last on element 5 ----------------
    for (int i = 0; i < 4; i++) send(8'h80 + 8'(i), 1'b0);
    send(8'h84, 1'b1);
    check("ferr_pulse", frame_err, 1);
    check("ferr_busy", busy, 0);
    check("ferr_in_ready", in_ready, 1);
    check("ferr_slot4_kept", mat_a_flat[4*BIT_LEN +: BIT_LEN], 8'h44);
    check("ferr_slot0_new", mat_a_flat[0 +: BIT_LEN], 8'h80);
    @(negedge clk);
    check("ferr_one_cycle", frame_err, 0);
    repeat (3) @(negedge clk);
    load(8'h90, 1'b0, 0);
    check("frame_ok_no_err", frame_err, 0);
    repeat (2) @(negedge clk);
    release_hold();
`endif

    // ---------------- drain scoreboard ----------------
    for (int w = 0; w < 5 && sb_q.size() != 0; w++) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
